// File: rtl/branch_predictor_pht.sv
// PC-indexed table of saturating counters with branch/mispredict counters.
// Define BP_GSHARE_EN to XOR a speculative global history into the index.
module branch_predictor_pht #(
  parameter int IDX_W = 6,
  parameter int CTR_W = 2,
  parameter int GHR_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lookup_valid_i,
  input  logic [31:0]      lookup_pc_i,
  output logic             predict_o,
  output logic [IDX_W-1:0] lookup_idx_o,
  output logic [GHR_W-1:0] lookup_ghr_o,
  input  logic             update_i,
  input  logic [IDX_W-1:0] update_idx_i,
  input  logic             update_taken_i,
  input  logic             update_mispredict_i,
  input  logic [GHR_W-1:0] update_ghr_i,
  output logic [31:0]      branch_cnt_o,
  output logic [31:0]      mispredict_cnt_o
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT =
    CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

  logic [CTR_W-1:0] pht [DEPTH];
  logic [CTR_W-1:0] upd_ctr;
  logic [31:0]      br_cnt_q;
  logic [31:0]      mis_cnt_q;
  logic [IDX_W-1:0] pc_idx;
  logic             mis_evt;
  logic             unused_pc;

  assign pc_idx    = lookup_pc_i[IDX_W+1:2];
  assign unused_pc = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};
  assign mis_evt   = update_i & update_mispredict_i;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;

  assign lookup_idx_o = pc_idx ^ IDX_W'(ghr_q);
  assign lookup_ghr_o = ghr_q;

  // Repair from EX wins over the speculative shift of a flushed lookup
  always_comb begin
    ghr_d = ghr_q;
    if (mis_evt)
      ghr_d = GHR_W'({update_ghr_i, update_taken_i});
    else if (lookup_valid_i)
      ghr_d = GHR_W'({ghr_q, predict_o});
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  logic unused_ghr;

  assign lookup_idx_o = pc_idx;
  assign lookup_ghr_o = '0;
  assign unused_ghr   = ^{update_ghr_i, lookup_valid_i};
`endif

  assign predict_o = pht[lookup_idx_o][CTR_W-1];

  always_comb begin
    upd_ctr = pht[update_idx_i];
    if (update_taken_i) begin
      if (upd_ctr != CTR_MAX) upd_ctr = upd_ctr + CTR_ONE;
    end else begin
      if (upd_ctr != '0) upd_ctr = upd_ctr - CTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= CTR_INIT;
    end else if (update_i) begin
      pht[update_idx_i] <= upd_ctr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (update_i) br_cnt_q  <= br_cnt_q + 32'd1;
      if (mis_evt)  mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign branch_cnt_o     = br_cnt_q;
  assign mispredict_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor_pht.sv
// Random and directed checks of branch_predictor_pht against a
// behavioural table/history model.
module tb_branch_predictor_pht;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        lookup_valid_i = 1'b0;
  logic [31:0] lookup_pc_i = '0;
  logic        predict_o;
  logic [5:0]  lookup_idx_o;
  logic [3:0]  lookup_ghr_o;
  logic        update_i = 1'b0;
  logic [5:0]  update_idx_i = '0;
  logic        update_taken_i = 1'b0;
  logic        update_mispredict_i = 1'b0;
  logic [3:0]  update_ghr_i = '0;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispredict_cnt_o;

  branch_predictor_pht dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .lookup_valid_i      (lookup_valid_i),
    .lookup_pc_i         (lookup_pc_i),
    .predict_o           (predict_o),
    .lookup_idx_o        (lookup_idx_o),
    .lookup_ghr_o        (lookup_ghr_o),
    .update_i            (update_i),
    .update_idx_i        (update_idx_i),
    .update_taken_i      (update_taken_i),
    .update_mispredict_i (update_mispredict_i),
    .update_ghr_i        (update_ghr_i),
    .branch_cnt_o        (branch_cnt_o),
    .mispredict_cnt_o    (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  int          ctr_m [64];
  int          ghr_m;
  logic [31:0] bcnt_m;
  logic [31:0] mcnt_m;

  logic [5:0] last_idx;
  logic       last_pred;
  logic [3:0] last_ghr;

`ifdef BP_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ctr_m[i] = 1;
    ghr_m  = 0;
    bcnt_m = '0;
    mcnt_m = '0;
  endtask

  // One clock: drive at negedge, check lookup, advance model at posedge
  task automatic step(bit lv, logic [31:0] pc, bit up, int ui,
                      bit tk, bit mis, int ug);
    int li;
    bit p;
    lookup_valid_i      = lv;
    lookup_pc_i         = pc;
    update_i            = up;
    update_idx_i        = ui[5:0];
    update_taken_i      = tk;
    update_mispredict_i = mis;
    update_ghr_i        = ug[3:0];
    #1;
    li = ((int'(pc) >>> 2) ^ ghr_m) & 63;
    p  = ctr_m[li] >= 2;
    last_idx  = lookup_idx_o;
    last_pred = predict_o;
    last_ghr  = lookup_ghr_o;
    if (lv) begin
      chk("idx", 32'(lookup_idx_o), 32'(li));
      chk("pred", 32'(predict_o), 32'(p));
      chk("ghr", 32'(lookup_ghr_o), 32'(ghr_m));
    end
    @(posedge clk_i);
    if (up) begin
      if (tk) ctr_m[ui] = (ctr_m[ui] == 3) ? 3 : ctr_m[ui] + 1;
      else    ctr_m[ui] = (ctr_m[ui] == 0) ? 0 : ctr_m[ui] - 1;
      bcnt_m = bcnt_m + 1;
      if (mis) mcnt_m = mcnt_m + 1;
    end
    if (GSHARE) begin
      if (up && mis)  ghr_m = ((ug << 1) | int'(tk)) & 15;
      else if (lv)    ghr_m = ((ghr_m << 1) | int'(p)) & 15;
    end
    #1;
    chk("bcnt", branch_cnt_o, bcnt_m);
    chk("mcnt", mispredict_cnt_o, mcnt_m);
    @(negedge clk_i);
  endtask

  initial begin
    int bad;
    model_reset();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;

    step(1, 32'h40, 0, 0, 0, 0, 0);
    chk("rst_idx", 32'(last_idx), 32'h10);
    chk("rst_pred", 32'(last_pred), 0);
    chk("rst_ghr", 32'(last_ghr), 0);

    step(0, 0, 1, 16, 1, 0, 0);
    chk("ctr_inc1", 32'(dut.pht[16]), 2);
    step(0, 0, 1, 16, 1, 0, 0);
    chk("ctr_inc2", 32'(dut.pht[16]), 3);
    step(1, 32'h40, 0, 0, 0, 0, 0);
    chk("trained_pred", 32'(last_pred), 1);
    step(0, 0, 1, 16, 1, 0, 0);
    chk("sat_hi", 32'(dut.pht[16]), 3);
    repeat (3) step(0, 0, 1, 16, 0, 0, 0);
    chk("dec_to_0", 32'(dut.pht[16]), 0);
    step(0, 0, 1, 16, 0, 0, 0);
    chk("sat_lo", 32'(dut.pht[16]), 0);

    step(0, 0, 1, 5, 1, 1, 1);
    step(1, 32'h40, 0, 0, 0, 0, 0);
    chk("ghr_idx", 32'(last_idx), GSHARE ? 32'h13 : 32'h10);

    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 16, 1, 0, 0);
    step(1, 32'h40, 1, 16, 1, 0, 0);
    chk("same_cyc_old", 32'(last_pred), 0);
    step(1, 32'h40, 0, 0, 0, 0, 0);
    chk("same_cyc_new", 32'(last_pred), 1);

    step(1, 32'h80, 1, 7, 1, 1, 5);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    chk("repair_ghr", 32'(last_ghr), GSHARE ? 32'hB : 32'h0);

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1), ($urandom & 32'hFFFF_FFC3) |
           ($urandom & 32'h3C), $urandom_range(0, 1),
           $urandom_range(0, 15), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 15));
    end

    force dut.mis_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mis_cnt_q;
    mcnt_m = 32'hFFFF_FFFF;
    step(0, 0, 1, 3, 1, 1, 0);
    chk("mcnt_wrap", mispredict_cnt_o, 0);

    for (int n = 0; n < 20; n++)
      step(1, $urandom, 1, $urandom_range(0, 63), 1, 1, 3);

    #2;
    rst_i = 1'b0;
    #1;
    chk("async_bcnt", branch_cnt_o, 0);
    chk("async_mcnt", mispredict_cnt_o, 0);
    chk("async_ghr", 32'(lookup_ghr_o), 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (dut.pht[i] !== 2'b01) bad++;
    chk("async_pht", bad, 0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int n = 0; n < 100; n++) begin
      step($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
           $urandom_range(0, 63), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 15));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_predictor_pht.md
Name: branch_predictor_pht

Overview:
- Parametrised successor to the single-counter branch predictor: a table of saturating counters indexed by PC, optionally XORed with a global history register (gshare).
- Lookup is combinational in ID and feeds the predict-taken path. Update comes from EX, where the branch unit resolves the branch and raises rollback.
- Each lookup returns the index and history snapshot it used. The ID_EX stage carries both, so EX updates the same entry and can repair history on a mispredict.
- Also keeps 32-bit performance counters for branches and mispredicts.

Parameters:
- IDX_W, 6: log2 of table depth; the table has 2^IDX_W entries.
- CTR_W, 2: width of each saturating counter. Must be 2..4.
- GHR_W, 4: global history length. Must be 1..IDX_W. Only used when the gshare macro is defined.

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: asynchronous, active-low reset.
- lookup_valid_i, input, 1: a branch in ID is advancing (branch & ~stall & ~flush).
- lookup_pc_i, input, 32: PC of the instruction in ID.
- predict_o, output, 1: predicted taken.
- lookup_idx_o, output, IDX_W: table index used for this lookup; carried to EX.
- lookup_ghr_o, output, GHR_W: history value before this lookup's shift; carried to EX.
- update_i, input, 1: a branch is resolved in EX this cycle.
- update_idx_i, input, IDX_W: index carried from the lookup.
- update_taken_i, input, 1: actual outcome (the zero flag for beq).
- update_mispredict_i, input, 1: rollback from the branch control unit.
- update_ghr_i, input, GHR_W: history snapshot carried from the lookup.
- branch_cnt_o, output, 32: number of resolved branches.
- mispredict_cnt_o, output, 32: number of mispredicts.

Behaviour:
- Reset (rst_i low, asynchronous):
  - every counter is set to weakly-not-taken, i.e. 2^(CTR_W-1)-1 (01 for CTR_W=2);
  - the history register is cleared to 0;
  - both performance counters are cleared to 0.
  - All state holds its reset value while rst_i stays low. Reset asserted mid-operation discards any in-flight update.
- Index: lookup_idx_o = lookup_pc_i[IDX_W+1:2] XOR the history register zero-extended to IDX_W bits (gshare on). PC bits [1:0] are ignored.
- Lookup (combinational, zero latency):
  - predict_o = MSB of the counter at lookup_idx_o;
  - lookup_ghr_o = current history register.
  - Both are valid whenever lookup_valid_i is high; they are don't-care otherwise.
- Counter update (on the clock edge when update_i=1):
  - taken: increment, saturating at 2^CTR_W-1;
  - not taken: decrement, saturating at 0.
  - Only the entry at update_idx_i changes.
- Same-cycle read and write to one index: the lookup sees the pre-update value. The new value is visible from the next cycle.
- History register, one action per clock edge, in this priority order:
  1. update_i & update_mispredict_i: history <= {update_ghr_i[GHR_W-2:0], update_taken_i}. A lookup in the same cycle is ignored, because that ID instruction is being flushed.
  2. lookup_valid_i: history <= {history[GHR_W-2:0], predict_o} (speculative shift).
  3. Otherwise: hold.
  - For GHR_W=1 the new history is just the single bit (update_taken_i or predict_o).
- update_mispredict_i without update_i is ignored.
- Performance counters: branch_cnt_o increments by 1 on every update_i; mispredict_cnt_o increments on update_i & update_mispredict_i. Both wrap from 0xFFFFFFFF to 0 with no saturation.
- No handshake and no backpressure. The caller must assert lookup_valid_i at most once per branch instance.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined: indexing and history behave as described above.
- Undefined (bimodal):
  - index = lookup_pc_i[IDX_W+1:2] only;
  - the history register is not built, lookup_ghr_o is tied to 0, update_ghr_i is ignored;
  - counter update and performance counters are unchanged.

Test Plan:
- Reset, then lookup at PC 0x40 with default parameters → lookup_idx_o=0x10, predict_o=0, lookup_ghr_o=0.
- Two updates at idx 0x10, taken=1, no other activity → counter 01→10→11; lookup at PC 0x40 then gives predict_o=1. A third taken update holds the counter at 11. Three not-taken updates bring it to 00; a fourth holds it at 00.
- Gshare on: after lookups that shift history to 0b0011, PC 0x40 → idx 0x13. With BP_GSHARE_EN undefined, the same sequence → idx 0x10.
- Same-cycle lookup and update at idx 0x10 with counter 01, taken=1 → predict_o=0 that cycle, predict_o=1 the next cycle.
- Same cycle: lookup_valid_i=1 and a mispredict with update_ghr_i=0b0101, taken=1 → history=0b1011, the lookup shift is dropped, branch_cnt_o and mispredict_cnt_o each +1.
- Preload mispredict_cnt_o near 0xFFFFFFFF via a forced reset value in simulation, then issue one mispredict update → count wraps to 0. Then assert rst_i low mid-run → counters read 0 and table entries read 01 immediately, with no clock edge needed.
